// File: rtl/ch_slot_scheduler.sv
// Cluster-head TDMA slot scheduler: collects membership requests, then walks the
// neighbor table and hands one consecutive timeslot per member to the reward packer.
module ch_slot_scheduler #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned TABLE_DEPTH = 32,
  parameter int unsigned MR_TIMEOUT  = 15,
  parameter int unsigned MAX_SLOTS   = 16,
  localparam int unsigned IDX_W      = $clog2(TABLE_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  role,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [IDX_W-1:0]      neighborCount,
  output logic [IDX_W-1:0]      nTableIndex,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mChosenCH,
  output logic                  pack_en,
  input  logic                  pack_done,
  output logic [WORD_WIDTH-1:0] slotNodeID,
  output logic [WORD_WIDTH-1:0] slotNumber,
  output logic [WORD_WIDTH-1:0] slotCount,
  output logic                  overflow,
  output logic                  busy,
  output logic                  sched_done
);

  localparam logic [IDX_W-1:0] IDX_IDLE = IDX_W'(TABLE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_MR, S_FETCH, S_CHECK, S_PACK, S_WAIT_DONE, S_DONE
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] timer;
  logic [IDX_W-1:0]      idx;

  logic [IDX_W-1:0] idx_next_c;
  logic             member_c;
  logic             slot_free_c;
  logic             advance_c;
  logic             last_c;

  // Entry evaluation: a member takes a slot only while slots remain.
  assign idx_next_c  = idx + IDX_W'(1);
  assign last_c      = (idx_next_c == neighborCount);
  assign member_c    = (mChosenCH == myNodeID);
  assign slot_free_c = (slotCount < WORD_WIDTH'(MAX_SLOTS));
  assign advance_c   = ((state == S_CHECK) && !(member_c && slot_free_c)) ||
                       ((state == S_WAIT_DONE) && pack_done);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= S_IDLE;
      timer       <= WORD_WIDTH'(MR_TIMEOUT);
      idx         <= '0;
      nTableIndex <= IDX_IDLE;
      pack_en     <= 1'b0;
      sched_done  <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      slotNodeID  <= '1;
      slotNumber  <= '0;
      slotCount   <= '0;
    end else if ((state != S_IDLE) && !role) begin
      // Losing the CH role abandons the schedule; partial counts are kept.
      state       <= S_IDLE;
      pack_en     <= 1'b0;
      sched_done  <= 1'b0;
      busy        <= 1'b0;
      nTableIndex <= IDX_IDLE;
    end else begin
      pack_en    <= 1'b0;
      sched_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && role) begin
            state     <= S_WAIT_MR;
            timer     <= WORD_WIDTH'(MR_TIMEOUT);
            idx       <= '0;
            slotCount <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_WAIT_MR: begin
          if (timer != '0) begin
            timer <= timer - WORD_WIDTH'(1);
          end else if (neighborCount == '0) begin
            state      <= S_DONE;
            sched_done <= 1'b1;
          end else begin
            state       <= S_FETCH;
            nTableIndex <= idx;
          end
        end
        S_FETCH: state <= S_CHECK;
        S_CHECK: begin
          if (member_c && slot_free_c) begin
            slotNodeID <= mNodeID;
            slotNumber <= slotCount + WORD_WIDTH'(1);
            slotCount  <= slotCount + WORD_WIDTH'(1);
            pack_en    <= 1'b1;
            state      <= S_PACK;
          end else if (member_c) begin
            overflow <= 1'b1;
          end
        end
        S_PACK:      state <= S_WAIT_DONE;
        S_WAIT_DONE: ;
        S_DONE: begin
          nTableIndex <= IDX_IDLE;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Move to the next table entry, or finish after the last one.
      if (advance_c) begin
        if (last_c) begin
          state      <= S_DONE;
          sched_done <= 1'b1;
        end else begin
          idx         <= idx_next_c;
          nTableIndex <= idx_next_c;
          state       <= S_FETCH;
        end
      end
    end
  end

endmodule
